cla_addsub_pipe: RTL and testbench



---
 rtl/cla_addsub_pipe.sv | 154 +++++++++++++++
 tb/tb_cla_addsub_pipe.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Optional signed saturation is enabled by defining CLA_ADDSUB_SAT_EN.
module cla_addsub_pipe #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned GROUP = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovfl,
   output logic             zero,
   output logic             neg
);

   localparam int unsigned NG  = WIDTH / GROUP;
   localparam int unsigned MSB = WIDTH - 1;

   if (GROUP != 4 || (WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_cfg
      $error("cla_addsub_pipe: GROUP must be 4 and WIDTH a multiple of 4 in 4..64");
   end

   logic [WIDTH-1:0] bb_c;
   logic             c0_c;
   logic [NG-1:0]    tg_d, tp_d;

   logic             s1_valid_q;
   logic [WIDTH-1:0] s1_a_q, s1_bb_q;
   logic             s1_c0_q;
   logic [NG-1:0]    s1_tg_q, s1_tp_q;

   logic             out_valid_q, cout_q, ovfl_q, zero_q, neg_q;
   logic [WIDTH-1:0] sum_q;

   logic             s2_adv_c, s1_adv_c;
   logic [NG:0]      gc_c;
   logic [WIDTH-1:0] p_c, g_c, raw_c, sum_d;
   logic             ovfl_d;

   assign s2_adv_c = ~out_valid_q | out_ready;
   assign s1_adv_c = ~s1_valid_q | s2_adv_c;
   assign in_ready = s1_adv_c;

   assign bb_c = sub ? ~b : b;
   assign c0_c = sub | cin;

   // Per-group generate/propagate of the 4-bit CLA slice, captured in S1
   for (genvar k = 0; k < NG; k++) begin : g_s1_grp
      logic [3:0] p, g;
      assign p       = a[k*4 +: 4] | bb_c[k*4 +: 4];
      assign g       = a[k*4 +: 4] & bb_c[k*4 +: 4];
      assign tp_d[k] = &p;
      assign tg_d[k] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_bb_q    <= '0;
         s1_c0_q    <= 1'b0;
         s1_tg_q    <= '0;
         s1_tp_q    <= '0;
      end else if (s1_adv_c) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_a_q  <= a;
            s1_bb_q <= bb_c;
            s1_c0_q <= c0_c;
            s1_tg_q <= tg_d;
            s1_tp_q <= tp_d;
         end
      end
   end

   // Second-level lookahead: every group carry is a flat sum of products of c0/TG/TP
   always_comb begin
      logic term;
      logic carry;
      term    = 1'b0;
      carry   = 1'b0;
      gc_c    = '0;
      gc_c[0] = s1_c0_q;
      for (int unsigned k = 0; k < NG; k++) begin
         term = s1_c0_q;
         for (int unsigned m = 0; m <= k; m++) term = term & s1_tp_q[m];
         carry = term;
         for (int unsigned j = 0; j <= k; j++) begin
            term = s1_tg_q[j];
            for (int unsigned m = j + 1; m <= k; m++) term = term & s1_tp_q[m];
            carry = carry | term;
         end
         gc_c[k+1] = carry;
      end
   end

   assign p_c = s1_a_q | s1_bb_q;
   assign g_c = s1_a_q & s1_bb_q;

   for (genvar k = 0; k < NG; k++) begin : g_s2_grp
      logic [3:0] c;
      assign c[0] = gc_c[k];
      for (genvar i = 1; i < 4; i++) begin : g_bit
         assign c[i] = g_c[k*4+i-1] | (p_c[k*4+i-1] & c[i-1]);
      end
      assign raw_c[k*4 +: 4] = s1_a_q[k*4 +: 4] ^ s1_bb_q[k*4 +: 4] ^ c;
   end

   assign ovfl_d = (s1_a_q[MSB] == s1_bb_q[MSB]) & (raw_c[MSB] != s1_a_q[MSB]);

`ifdef CLA_ADDSUB_SAT_EN
   // Clamp toward the sign of A; flags other than zero/neg describe the raw result
   assign sum_d = !ovfl_d ? raw_c :
                  s1_a_q[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
   assign sum_d = raw_c;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovfl_q      <= 1'b0;
         zero_q      <= 1'b1;
         neg_q       <= 1'b0;
      end else if (s2_adv_c) begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            sum_q  <= sum_d;
            cout_q <= gc_c[NG];
            ovfl_q <= ovfl_d;
            zero_q <= (sum_d == '0);
            neg_q  <= sum_d[MSB];
         end
      end
   end

   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovfl      = ovfl_q;
   assign zero      = zero_q;
   assign neg       = neg_q;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Self-checking bench for cla_addsub_pipe: directed vectors at WIDTH=16, then random
// handshaking across WIDTH=4/16/32 instances against an arithmetic reference.
module tb_cla_addsub_pipe;

   logic        clk = 1'b0;
   logic        rst, in_valid, cin, sub, out_ready;
   logic [31:0] a32, b32;

   logic        rdy4, ov4, co4, of4, z4, n4;
   logic [3:0]  s4;
   logic        rdy16, ov16, co16, of16, z16, n16;
   logic [15:0] s16;
   logic        rdy32, ov32, co32, of32, z32, n32;
   logic [31:0] s32;

   int n_chk = 0;
   int n_pass = 0;
   int acc_cnt = 0;
   int n_push = 0;
   int n_out = 0;
   logic mon_en = 1'b0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sub;
   } beat_t;
   beat_t sb[$];

   always #5 clk = ~clk;

   cla_addsub_pipe #(.WIDTH(4)) u4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .a(a32[3:0]), .b(b32[3:0]),
      .cin(cin), .sub(sub), .out_valid(ov4), .out_ready(out_ready), .sum(s4), .cout(co4),
      .ovfl(of4), .zero(z4), .neg(n4));

   cla_addsub_pipe #(.WIDTH(16)) u16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16), .a(a32[15:0]), .b(b32[15:0]),
      .cin(cin), .sub(sub), .out_valid(ov16), .out_ready(out_ready), .sum(s16), .cout(co16),
      .ovfl(of16), .zero(z16), .neg(n16));

   cla_addsub_pipe #(.WIDTH(32)) u32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32), .a(a32), .b(b32),
      .cin(cin), .sub(sub), .out_valid(ov32), .out_ready(out_ready), .sum(s32), .cout(co32),
      .ovfl(of32), .zero(z32), .neg(n32));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
   endtask

   // Packed view: {out_valid, cout, ovfl, zero, neg, sum zero-extended to 32}
   function automatic logic [63:0] obs16();
      return 64'({ov16, co16, of16, z16, n16, 16'h0, s16});
   endfunction
   function automatic logic [63:0] obs4();
      return 64'({ov4, co4, of4, z4, n4, 28'h0, s4});
   endfunction
   function automatic logic [63:0] obs32();
      return 64'({ov32, co32, of32, z32, n32, s32});
   endfunction

   function automatic logic [63:0] exp16(input logic [15:0] s, input logic co, input logic of);
      return 64'({1'b1, co, of, (s == 16'h0), s[15], 16'h0, s});
   endfunction

   localparam logic [63:0] RST16 = 64'({5'b00010, 32'h0});

   function automatic logic [63:0] model(input int w, input beat_t t);
      logic [63:0] mask, aa, bb, full;
      logic [31:0] s;
      logic        co, ov, am;
      mask = (64'd1 << w) - 64'd1;
      aa   = {32'h0, t.a} & mask;
      bb   = (t.sub ? ~{32'h0, t.b} : {32'h0, t.b}) & mask;
      full = aa + bb + (t.sub ? 64'd1 : {63'h0, t.cin});
      s    = 32'(full & mask);
      co   = full[w];
      am   = aa[w-1];
      ov   = (am == bb[w-1]) && (s[w-1] != am);
`ifdef CLA_ADDSUB_SAT_EN
      if (ov) s = am ? (32'd1 << (w - 1)) : ((32'd1 << (w - 1)) - 32'd1);
`endif
      return 64'({1'b1, co, ov, (s == 32'h0), s[w-1], s});
   endfunction

`ifdef CLA_ADDSUB_SAT_EN
   localparam logic [15:0] POS_OV_SUM = 16'h7FFF;
   localparam logic [15:0] NEG_OV_SUM = 16'h8000;
`else
   localparam logic [15:0] POS_OV_SUM = 16'h8000;
   localparam logic [15:0] NEG_OV_SUM = 16'h7FFF;
`endif

   // One beat through an empty pipe: ready when offered, invisible after one edge, valid after two
   task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic sb_, input logic [15:0] es,
                          input logic eco, input logic eof);
      @(posedge clk); #1;
      in_valid = 1'b1; a32 = {a, a}; b32 = {b, b}; cin = ci; sub = sb_; out_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_rdy"}, 64'(rdy16), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_lat1"}, 64'(ov16), 64'd0);
      @(negedge clk);
      chk(tag, obs16(), exp16(es, eco, eof));
   endtask

   // Acceptance counter plus random-phase scoreboard and hold checker
   logic        hold_pend = 1'b0;
   logic [63:0] hold_val;
   always @(negedge clk) begin
      beat_t t;
      if (!rst && in_valid && rdy16) acc_cnt++;
      if (mon_en && !rst) begin
         if (hold_pend) chk("rnd_hold", obs16(), hold_val);
         hold_pend = ov16 && !out_ready;
         hold_val  = obs16();
         if (ov16 && out_ready) begin
            chk("rnd_sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               t = sb.pop_front();
               chk("rnd_w4", obs4(), model(4, t));
               chk("rnd_w16", obs16(), model(16, t));
               chk("rnd_w32", obs32(), model(32, t));
               n_out++;
            end
         end
         if (in_valid && rdy16) begin
            t.a = a32; t.b = b32; t.cin = cin; t.sub = sub;
            sb.push_back(t);
            n_push++;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired n_chk=%0d", n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      int base, cyc;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0; sub = 1'b0;
      a32 = '0; b32 = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_out", obs16(), RST16);
      chk("reset_rdy", 64'(rdy16), 64'd1);

      run_one("carry_chain", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_one("pos_ovfl",    16'h7FFF, 16'h0001, 1'b0, 1'b0, POS_OV_SUM, 1'b0, 1'b1);
      run_one("sub_borrow",  16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
      run_one("neg_ovfl",    16'h8000, 16'h0001, 1'b0, 1'b1, NEG_OV_SUM, 1'b1, 1'b1);
      run_one("add_cin",     16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
      run_one("cin_group",   16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
      run_one("sub_eq",      16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
      run_one("sub_cin_ign", 16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000D, 1'b1, 1'b0);

      // Backpressure: two beats held, third stalled, then drain in order
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; cin = 1'b0; sub = 1'b0; a32 = 32'd1; b32 = 32'd1;
      base = acc_cnt;
      @(negedge clk);
      chk("bp_rdy1", 64'(rdy16), 64'd1);
      @(posedge clk); #1 a32 = 32'd2; b32 = 32'd2;
      @(negedge clk);
      chk("bp_rdy2", 64'(rdy16), 64'd1);
      @(posedge clk); #1 a32 = 32'd3; b32 = 32'd3;
      @(negedge clk);
      chk("bp_rdy3", 64'(rdy16), 64'd0);
      chk("bp_out2", obs16(), exp16(16'd2, 1'b0, 1'b0));
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_rdy4", 64'(rdy16), 64'd0);
      chk("bp_hold", obs16(), exp16(16'd2, 1'b0, 1'b0));
      chk("bp_acc", 64'(acc_cnt - base), 64'd2);
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
      chk("bp_rdy_rise", 64'(rdy16), 64'd1);
      @(posedge clk); #1 a32 = 32'd4; b32 = 32'd4;
      @(negedge clk);
      chk("bp_r4", obs16(), exp16(16'd4, 1'b0, 1'b0));
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk("bp_r6", obs16(), exp16(16'd6, 1'b0, 1'b0));
      @(negedge clk);
      chk("bp_r8", obs16(), exp16(16'd8, 1'b0, 1'b0));
      @(negedge clk);
      chk("bp_empty", 64'(ov16), 64'd0);

      // Reset with two beats in flight discards both
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; a32 = 32'd7; b32 = 32'd7;
      @(posedge clk); #1 a32 = 32'd9; b32 = 32'd9;
      @(posedge clk); #1 in_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_out", obs16(), RST16);
      chk("rst_mid_rdy", 64'(rdy16), 64'd1);
      run_one("rst_new", 16'h0005, 16'h0003, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0);

      // Random handshaking on all three widths
      @(posedge clk); #1;
      mon_en = 1'b1;
      cyc = 0;
      while (n_push < 10000 && cyc < 40000) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         a32 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom();
         b32 = ($urandom_range(0, 7) == 0) ? 32'h0000_0001 : $urandom();
         cin = 1'($urandom_range(0, 1));
         sub = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      cyc = 0;
      while (sb.size() != 0 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      @(negedge clk);
      mon_en = 1'b0;
      chk("rnd_beats", 64'(n_push >= 10000), 64'd1);
      chk("rnd_drain", 64'(sb.size()), 64'd0);
      chk("rnd_count", 64'(n_out), 64'(n_push));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
